byte_demux_writer: RTL and testbench

//   Write-side counterpart of the 4-byte read mux. Accepts a byte stream over a valid/ready

---
 rtl/byte_demux_writer.sv | 161 ++++++++++++++++
 tb/tb_byte_demux_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_demux_writer.sv
// byte_demux_writer
//   Write side of the 4-byte register file. Bytes arrive over a valid/ready
//   handshake and are steered into one of four 8-bit storage registers
//   (mem0..mem3). A transaction is either a single addressed write or an
//   auto-incrementing burst of BURST_LEN beats whose pointer wraps 3 -> 0.
//   Each transaction ends with a one-cycle DONE state in which wr_ready is
//   low and wr_done pulses.
//
// Parameters
//   BURST_LEN  beats per burst (1..255)
//   RESET_VAL  value loaded into every storage register on reset
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   wr_valid  in   wr_data/wr_sel/wr_burst valid this cycle
//   wr_ready  out  beat accepted when wr_valid & wr_ready
//   wr_data   in   [7:0] byte to store
//   wr_sel    in   [1:0] target register, used on the first beat only
//   wr_burst  in   first beat only: 0 = single write, 1 = burst from wr_sel
//   mem0..3   out  [7:0] storage registers
//   mem_par   out  [3:0] even parity of each stored byte (BYTE_PARITY_EN only)
//   wr_done   out  one-cycle pulse when a transaction completes
//   wr_busy   out  high while a burst is in progress or in DONE
//
// Configuration
//   `define BYTE_PARITY_EN to add the mem_par output and its parity registers.

module byte_demux_writer #(
  parameter int         BURST_LEN = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic [1:0] wr_sel,
  input  logic       wr_burst,
  output logic [7:0] mem0,
  output logic [7:0] mem1,
  output logic [7:0] mem2,
  output logic [7:0] mem3,
`ifdef BYTE_PARITY_EN
  output logic [3:0] mem_par,
`endif
  output logic       wr_done,
  output logic       wr_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Beats still owed once the first beat of a burst has been taken.
  localparam logic [7:0] BEATS_AFTER_FIRST = 8'(BURST_LEN - 1);
  // A one-beat burst is indistinguishable from a single write.
  localparam bit         SINGLE_BEAT_BURST = (BURST_LEN == 1);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] remaining_reg, remaining_next;

  logic       beat;
  logic       wr_en;
  logic [1:0] wr_idx;

  logic [7:0] mem_reg [4];

  assign wr_ready = (state_reg != DONE) && !reset;
  assign beat     = wr_valid && wr_ready;
  assign wr_done  = (state_reg == DONE);
  assign wr_busy  = (state_reg == BURST) || (state_reg == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd0;
      remaining_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    wr_en          = 1'b0;
    wr_idx         = ptr_reg;

    case (state_reg)
      IDLE: begin
        if (beat) begin
          // First beat writes straight to the addressed register.
          wr_en  = 1'b1;
          wr_idx = wr_sel;
          if (!wr_burst || SINGLE_BEAT_BURST) begin
            state_next = DONE;
          end else begin
            ptr_next       = wr_sel + 2'd1;
            remaining_next = BEATS_AFTER_FIRST;
            state_next     = BURST;
          end
        end
      end
      BURST: begin
        // Without a beat everything holds; a burst may stall indefinitely.
        if (beat) begin
          wr_en          = 1'b1;
          wr_idx         = ptr_reg;
          ptr_next       = ptr_reg + 2'd1;
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One storage register per byte lane; only the addressed lane updates.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= RESET_VAL;
        end else if (wr_en && (wr_idx == 2'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end

`ifdef BYTE_PARITY_EN
      // Parity is captured alongside its byte so the two never disagree.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_par[gi] <= ^RESET_VAL;
        end else if (wr_en && (wr_idx == 2'(gi))) begin
          mem_par[gi] <= ^wr_data;
        end
      end
`endif
    end
  endgenerate

  assign mem0 = mem_reg[0];
  assign mem1 = mem_reg[1];
  assign mem2 = mem_reg[2];
  assign mem3 = mem_reg[3];

endmodule

// File: tb/tb_byte_demux_writer.sv
// tb_byte_demux_writer
//   Drives two writers (BURST_LEN 4 and 6) and compares their storage,
//   handshake and status outputs against a simple array model in which a
//   transaction of n beats starting at sel writes byte k to (sel + k) mod 4.

module tb_byte_demux_writer;

  localparam int L0 = 4;
  localparam int L1 = 6;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       wr_valid [2];
  logic       wr_burst [2];
  logic [7:0] wr_data  [2];
  logic [1:0] wr_sel   [2];
  logic       wr_ready [2];
  logic       wr_done  [2];
  logic       wr_busy  [2];
  logic [7:0] mem_o    [2][4];
`ifdef BYTE_PARITY_EN
  logic [3:0] mem_par  [2];
`endif

  byte_demux_writer #(.BURST_LEN(L0), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
    .wr_sel(wr_sel[0]), .wr_burst(wr_burst[0]),
    .mem0(mem_o[0][0]), .mem1(mem_o[0][1]), .mem2(mem_o[0][2]), .mem3(mem_o[0][3]),
`ifdef BYTE_PARITY_EN
    .mem_par(mem_par[0]),
`endif
    .wr_done(wr_done[0]), .wr_busy(wr_busy[0])
  );

  byte_demux_writer #(.BURST_LEN(L1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
    .wr_sel(wr_sel[1]), .wr_burst(wr_burst[1]),
    .mem0(mem_o[1][0]), .mem1(mem_o[1][1]), .mem2(mem_o[1][2]), .mem3(mem_o[1][3]),
`ifdef BYTE_PARITY_EN
    .mem_par(mem_par[1]),
`endif
    .wr_done(wr_done[1]), .wr_busy(wr_busy[1])
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [2][4];
  logic [7:0] dir_data [8];
  int         dir_n = 0;

  function automatic int blen(int d);
    return (d == 0) ? L0 : L1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mems(int d);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dut%0d mem%0d", d, i), 32'(mem_o[d][i]), 32'(model[d][i]));
`ifdef BYTE_PARITY_EN
      chk($sformatf("dut%0d mem_par%0d", d, i), 32'(mem_par[d][i]), 32'(^model[d][i]));
`endif
    end
  endtask

  task automatic check_status(int d, string tag, logic rdy, logic done, logic busy);
    chk($sformatf("dut%0d %s wr_ready", d, tag), 32'(wr_ready[d]), 32'(rdy));
    chk($sformatf("dut%0d %s wr_done", d, tag), 32'(wr_done[d]), 32'(done));
    chk($sformatf("dut%0d %s wr_busy", d, tag), 32'(wr_busy[d]), 32'(busy));
  endtask

  // Presents one beat and waits (bounded) for it to be accepted at an edge.
  task automatic beat(int d, logic [7:0] data, logic [1:0] sel, logic burst);
    bit ok;
    int n;
    wr_valid[d] = 1'b1;
    wr_data[d]  = data;
    wr_sel[d]   = sel;
    wr_burst[d] = burst;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 10) begin
      ok = wr_ready[d];
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid[d] = 1'b0;
    wr_data[d]  = 8'($urandom);
    wr_sel[d]   = 2'($urandom);
    wr_burst[d] = 1'($urandom);
    chk($sformatf("dut%0d beat accepted", d), 32'(ok), 32'd1);
  endtask

  // One full transaction. Directed data is taken from dir_data[0..dir_n-1],
  // the rest is random. stall_after/stall_len give a fixed stall; rand_stall
  // adds up to that many random idle cycles between burst beats.
  task automatic txn(int d, logic [1:0] sel, logic burst,
                     int stall_after, int stall_len, int rand_stall);
    int nb;
    int ns;
    logic [7:0] data;
    nb = burst ? blen(d) : 1;
    for (int k = 0; k < nb; k++) begin
      data = (k < dir_n) ? dir_data[k] : 8'($urandom);
      if (k == 0) beat(d, data, sel, burst);
      else        beat(d, data, 2'($urandom), 1'($urandom));
      model[d][(int'(sel) + k) % 4] = data;
      check_mems(d);
      if (k < nb - 1) begin
        check_status(d, "mid-burst", 1'b1, 1'b0, 1'b1);
        ns = (k == stall_after) ? stall_len : 0;
        if (rand_stall > 0) ns += $urandom_range(0, rand_stall);
        for (int s = 0; s < ns; s++) begin
          @(posedge clk);
          #1;
          check_status(d, "stall", 1'b1, 1'b0, 1'b1);
        end
      end
    end
    check_status(d, "done", 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_status(d, "after done", 1'b1, 1'b0, 1'b0);
    check_mems(d);
    dir_n = 0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wr_valid[d] = 1'b0;
      wr_data[d]  = 8'h00;
      wr_sel[d]   = 2'd0;
      wr_burst[d] = 1'b0;
      for (int i = 0; i < 4; i++) model[d][i] = 8'h00;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_status(d, "in reset", 1'b0, 1'b0, 1'b0);
      check_mems(d);
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_status(d, "reset release", 1'b1, 1'b0, 1'b0);

    // Single write A5 to mem2
    dir_data[0] = 8'hA5; dir_n = 1;
    txn(0, 2'd2, 1'b0, -1, 0, 0);
    chk("single mem2", 32'(mem_o[0][2]), 32'h A5);
    chk("single mem0", 32'(mem_o[0][0]), 32'h00);

    // 4-beat burst from mem2, back to back
    dir_data[0] = 8'h11; dir_data[1] = 8'h22; dir_data[2] = 8'h33; dir_data[3] = 8'h44;
    dir_n = 4;
    txn(0, 2'd2, 1'b1, -1, 0, 0);
    chk("burst mem2", 32'(mem_o[0][2]), 32'h11);
    chk("burst mem3", 32'(mem_o[0][3]), 32'h22);
    chk("burst mem0", 32'(mem_o[0][0]), 32'h33);
    chk("burst mem1", 32'(mem_o[0][1]), 32'h44);

    // Same burst with a 3-cycle stall after beat 2
    dir_data[0] = 8'h11; dir_data[1] = 8'h22; dir_data[2] = 8'h33; dir_data[3] = 8'h44;
    dir_n = 4;
    txn(0, 2'd2, 1'b1, 1, 3, 0);

    // 6-beat burst from mem0 wraps and overwrites mem0/mem1
    for (int k = 0; k < 6; k++) dir_data[k] = 8'(k + 1);
    dir_n = 6;
    txn(1, 2'd0, 1'b1, -1, 0, 0);
    chk("len6 mem0", 32'(mem_o[1][0]), 32'h05);
    chk("len6 mem1", 32'(mem_o[1][1]), 32'h06);
    chk("len6 mem2", 32'(mem_o[1][2]), 32'h03);
    chk("len6 mem3", 32'(mem_o[1][3]), 32'h04);

    // Random transactions on both writers
    for (int t = 0; t < 40; t++) begin
      txn(t % 2, 2'($urandom), 1'($urandom), -1, 0, 2);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of a 4-beat burst
    beat(0, 8'hDE, 2'd1, 1'b1);
    model[0][1] = 8'hDE;
    beat(0, 8'hAD, 2'd3, 1'b0);
    model[0][2] = 8'hAD;
    check_mems(0);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) model[d][i] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      check_status(d, "mid-burst reset", 1'b0, 1'b0, 1'b0);
      check_mems(d);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_status(0, "after abort", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_status(0, "idle after abort", 1'b1, 1'b0, 1'b0);
    check_mems(0);

    // Fresh single write after the abort
    dir_data[0] = 8'h07; dir_n = 1;
    txn(0, 2'd1, 1'b0, -1, 0, 0);
    chk("post-abort mem1", 32'(mem_o[0][1]), 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
